// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-I subset core: opcode and funct
// encodings, FSM states, ALU operations and a sign-extension helper.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  typedef enum logic [2:0] {
    StFh,  // fetch high half-word
    StFl,  // fetch low half-word
    StEx,  // execute, bus idle
    StMh,  // memory high half-word
    StMl   // memory low half-word
  } state_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_if.sv
// Control side of the asynchronous 256K x 16 SRAM bus. All strobes are active-low.
// The 16-bit data bus is bidirectional and travels as a separate inout port.
interface mips_if;
  logic [17:0] addr;
  logic        wre;
  logic        oute;
  logic        hb_mask;
  logic        lb_mask;
  logic        chip_en;

  modport master (output addr, wre, oute, hb_mask, lb_mask, chip_en);
  modport slave  (input  addr, wre, oute, hb_mask, lb_mask, chip_en);
endinterface

// File: rtl/mips_regfile.sv
// 32 x 32 general-purpose register file: two asynchronous read ports, one
// synchronous write port, synchronous clear. Register $0 is hard-wired to zero.
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] rf_q [32];

  // Clear on reset, otherwise write one register; writes to $0 are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0 : rf_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0 : rf_q[raddr_b_i];

endmodule

// File: rtl/mips_core.sv
// Multicycle MIPS-I subset CPU running directly out of a 256K x 16 async SRAM.
// Every 32-bit word occupies two half-words, high half at the even address.
module mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clock,
  input  logic       reset,
  mips_if.master     bus,
  inout  wire [15:0] data
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [16:0] ea_q;      // word index of the load/store target
  logic [15:0] tmp_q;     // high half of a load in flight
  logic        bus_en_q;  // low for the first cycle after reset: bus stays idle

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];

  logic [15:0] data_in;
  assign data_in = data;

  logic [31:0] rs_val, rt_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  mips_regfile u_regfile (
    .clk_i     (clock),
    .rst_i     (reset),
    .raddr_a_i (rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (rt),
    .rdata_b_o (rt_val),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  // Decode: ALU operation, operand source and write-back destination.
  alu_op_e alu_op;
  logic    use_imm, imm_zero, wb_en, wb_rd;
  always_comb begin
    alu_op   = AluAdd;
    use_imm  = 1'b0;
    imm_zero = 1'b0;
    wb_en    = 1'b0;
    wb_rd    = 1'b0;
    case (opcode)
      OpRtype: begin
        wb_en = 1'b1;
        wb_rd = 1'b1;
        case (funct)
          FnAdd, FnAddu: alu_op = AluAdd;
          FnSub, FnSubu: alu_op = AluSub;
          FnAnd:         alu_op = AluAnd;
          FnOr:          alu_op = AluOr;
          FnXor:         alu_op = AluXor;
          FnNor:         alu_op = AluNor;
          FnSlt:         alu_op = AluSlt;
          FnSltu:        alu_op = AluSltu;
          FnSll:         alu_op = AluSll;
          FnSrl:         alu_op = AluSrl;
          FnSra:         alu_op = AluSra;
          default:       wb_en  = 1'b0;  // unknown funct behaves as a NOP
        endcase
      end
      OpAddi, OpAddiu: begin alu_op = AluAdd;  use_imm = 1'b1; wb_en = 1'b1; end
      OpSlti:          begin alu_op = AluSlt;  use_imm = 1'b1; wb_en = 1'b1; end
      OpSltiu:         begin alu_op = AluSltu; use_imm = 1'b1; wb_en = 1'b1; end
      OpAndi: begin alu_op = AluAnd; use_imm = 1'b1; imm_zero = 1'b1; wb_en = 1'b1; end
      OpOri:  begin alu_op = AluOr;  use_imm = 1'b1; imm_zero = 1'b1; wb_en = 1'b1; end
      OpXori: begin alu_op = AluXor; use_imm = 1'b1; imm_zero = 1'b1; wb_en = 1'b1; end
      OpLui:  begin alu_op = AluLui; wb_en = 1'b1; end
      default: ;
    endcase
  end

  logic [31:0] imm_sext, alu_b, alu_res;
  assign imm_sext = sext16(imm);
  assign alu_b    = !use_imm ? rt_val : (imm_zero ? {16'h0, imm} : imm_sext);

  // ALU: 32-bit wrapping arithmetic, shifts by shamt.
  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      AluAdd:  alu_res = rs_val + alu_b;
      AluSub:  alu_res = rs_val - alu_b;
      AluAnd:  alu_res = rs_val & alu_b;
      AluOr:   alu_res = rs_val | alu_b;
      AluXor:  alu_res = rs_val ^ alu_b;
      AluNor:  alu_res = ~(rs_val | alu_b);
      AluSlt:  alu_res = {31'h0, $signed(rs_val) < $signed(alu_b)};
      AluSltu: alu_res = {31'h0, rs_val < alu_b};
      AluSll:  alu_res = alu_b << shamt;
      AluSrl:  alu_res = alu_b >> shamt;
      AluSra:  alu_res = $unsigned($signed(alu_b) >>> shamt);
      AluLui:  alu_res = {imm, 16'h0};
      default: alu_res = 32'h0;
    endcase
  end

  logic [31:0] pc_plus4, br_target, j_target, ea;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign ea        = rs_val + imm_sext;

  // Word alignment and the 512 KB wrap drop these address bits.
  logic unused_ea;
  assign unused_ea = ^{ea[31:19], ea[1:0]};

  logic is_lw, is_sw;
  assign is_lw = (opcode == OpLw);
  assign is_sw = (opcode == OpSw);

  // Register write-back: ALU results at the end of EX, load data at the end of ML.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_rd ? rd : rt;
    rf_wdata = alu_res;
    if (state_q == StEx) begin
      rf_we = wb_en;
    end else if (state_q == StMl && is_lw) begin
      rf_we    = 1'b1;
      rf_waddr = rt;
      rf_wdata = {tmp_q, data_in};
    end
  end

  // Control FSM, program counter, instruction register and load/store latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StFh;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      ea_q     <= '0;
      tmp_q    <= 16'h0;
      bus_en_q <= 1'b0;
    end else if (!bus_en_q) begin
      bus_en_q <= 1'b1;
    end else begin
      case (state_q)
        StFh: begin
          ir_q[31:16] <= data_in;
          state_q     <= StFl;
        end
        StFl: begin
          ir_q[15:0] <= data_in;
          state_q    <= StEx;
        end
        StEx: begin
          state_q <= StFh;
          pc_q    <= pc_plus4;
          case (opcode)
            OpLw, OpSw: begin
              ea_q    <= ea[18:2];
              pc_q    <= pc_q;
              state_q <= StMh;
            end
            OpBeq:   if (rs_val == rt_val) pc_q <= br_target;
            OpBne:   if (rs_val != rt_val) pc_q <= br_target;
            OpJ:     pc_q <= j_target;
            default: ;
          endcase
        end
        StMh: begin
          if (is_lw) tmp_q <= data_in;
          state_q <= StMl;
        end
        StMl: begin
          pc_q    <= pc_plus4;
          state_q <= StFh;
        end
        default: state_q <= StFh;
      endcase
    end
  end

  // SRAM strobes decoded from registered state only.
  logic access, wr_cyc;
  assign access = bus_en_q && (state_q != StEx);
  assign wr_cyc = access && (state_q == StMh || state_q == StMl) && is_sw;

  always_comb begin
    bus.chip_en = ~access;
    bus.hb_mask = ~access;
    bus.lb_mask = ~access;
    bus.oute    = ~(access && !wr_cyc);
    bus.wre     = ~wr_cyc;
    bus.addr    = 18'h0;
    if (bus_en_q) begin
      case (state_q)
        StFh:    bus.addr = {pc_q[18:2], 1'b0};
        StFl:    bus.addr = {pc_q[18:2], 1'b1};
        StMh:    bus.addr = {ea_q, 1'b0};
        StMl:    bus.addr = {ea_q, 1'b1};
        default: bus.addr = 18'h0;
      endcase
    end
  end

  assign data = wr_cyc ? ((state_q == StMh) ? rt_val[31:16] : rt_val[15:0]) : 16'hzzzz;

endmodule

// File: tb/tb_mips_core.sv
// Bench for mips_core: SRAM array model, directed programs and randomized
// programs checked against an instruction-level reference interpreter.
module tb_mips_core;
  import mips_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  wire [15:0] data;

  mips_if bus ();

  mips_core #(.RESET_PC(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .data  (data)
  );

  logic [15:0] mem   [0:262143];
  logic [31:0] m_mem [0:4095];
  logic [31:0] prog  [$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign data = (!bus.chip_en && !bus.oute && bus.wre) ? mem[bus.addr] : 16'hzzzz;

  // One clock: sample the bus at the negedge, commit any SRAM write at the posedge.
  task automatic clk_cycle();
    logic we;
    logic [17:0] wa;
    logic [15:0] wd;
    we = !bus.chip_en && !bus.wre;
    wa = bus.addr;
    wd = data;
    @(posedge clock);
    if (we) mem[wa] = wd;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs,
                                        input int rt, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {OpJ, 26'(target >> 2)};
  endfunction

  function automatic logic [31:0] mem_word(input int byte_addr);
    int i;
    i = (byte_addr >> 2) * 2;
    return {mem[i], mem[i + 1]};
  endfunction

  // Hold reset, wipe the low memory, load prog at address 0.
  task automatic prep_prog();
    reset = 1'b1;
    clk_cycle();
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
    for (int i = 0; i < 4096; i++) m_mem[i] = 32'h0;
    foreach (prog[i]) begin
      mem[2 * i]     = prog[i][31:16];
      mem[2 * i + 1] = prog[i][15:0];
      m_mem[i]       = prog[i];
    end
    clk_cycle();
  endtask

  // Release reset; returns in cycle 0 (fetch of the first half-word).
  task automatic go();
    reset = 1'b0;
    clk_cycle();
  endtask

  // Instruction-level interpreter: runs until a jump-to-self, totals the cycles.
  task automatic model_run(output int cycles, output logic [31:0] jpc);
    logic [31:0] r [0:31];
    logic [31:0] pc, ins, a, b, se, ze, ea, nxt;
    logic [4:0]  rt_i, rd_i;
    int sh;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    pc = 32'h0;
    cycles = 0;
    jpc = 32'hFFFF_FFFF;
    for (int step = 0; step < 4000; step++) begin
      ins  = m_mem[pc[13:2]];
      a    = r[ins[25:21]];
      b    = r[ins[20:16]];
      rt_i = ins[20:16];
      rd_i = ins[15:11];
      sh   = int'(ins[10:6]);
      se   = {{16{ins[15]}}, ins[15:0]};
      ze   = {16'h0, ins[15:0]};
      nxt  = pc + 32'd4;
      if (ins[31:26] == OpJ && {nxt[31:28], ins[25:0], 2'b00} == pc) begin
        jpc = pc;
        break;
      end
      cycles += 3;
      case (ins[31:26])
        OpRtype: begin
          case (ins[5:0])
            FnAdd, FnAddu: r[rd_i] = a + b;
            FnSub, FnSubu: r[rd_i] = a - b;
            FnAnd:  r[rd_i] = a & b;
            FnOr:   r[rd_i] = a | b;
            FnXor:  r[rd_i] = a ^ b;
            FnNor:  r[rd_i] = ~(a | b);
            FnSlt:  r[rd_i] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            FnSltu: r[rd_i] = (a < b) ? 32'd1 : 32'd0;
            FnSll:  r[rd_i] = b << sh;
            FnSrl:  r[rd_i] = b >> sh;
            FnSra:  r[rd_i] = $unsigned($signed(b) >>> sh);
            default: ;
          endcase
        end
        OpAddi, OpAddiu: r[rt_i] = a + se;
        OpSlti:  r[rt_i] = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        OpSltiu: r[rt_i] = (a < se) ? 32'd1 : 32'd0;
        OpAndi:  r[rt_i] = a & ze;
        OpOri:   r[rt_i] = a | ze;
        OpXori:  r[rt_i] = a ^ ze;
        OpLui:   r[rt_i] = {ins[15:0], 16'h0};
        OpLw: begin ea = a + se; r[rt_i] = m_mem[ea[13:2]]; cycles += 2; end
        OpSw: begin ea = a + se; m_mem[ea[13:2]] = b; cycles += 2; end
        OpBeq:   if (a == b) nxt = pc + 32'd4 + (se << 2);
        OpBne:   if (a != b) nxt = pc + 32'd4 + (se << 2);
        OpJ:     nxt = {nxt[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      r[0] = 32'h0;
      pc   = nxt;
    end
  endtask

  function automatic logic [31:0] rand_alu();
    int d, s, t, sh;
    logic [15:0] imm;
    d   = int'($urandom_range(0, 7));
    s   = int'($urandom_range(0, 7));
    t   = int'($urandom_range(0, 7));
    sh  = int'($urandom_range(0, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 22))
      0:  return enc_r(FnAdd, d, s, t, 0);
      1:  return enc_r(FnAddu, d, s, t, 0);
      2:  return enc_r(FnSub, d, s, t, 0);
      3:  return enc_r(FnSubu, d, s, t, 0);
      4:  return enc_r(FnAnd, d, s, t, 0);
      5:  return enc_r(FnOr, d, s, t, 0);
      6:  return enc_r(FnXor, d, s, t, 0);
      7:  return enc_r(FnNor, d, s, t, 0);
      8:  return enc_r(FnSlt, d, s, t, 0);
      9:  return enc_r(FnSltu, d, s, t, 0);
      10: return enc_r(FnSll, d, 0, t, sh);
      11: return enc_r(FnSrl, d, 0, t, sh);
      12: return enc_r(FnSra, d, 0, t, sh);
      13: return enc_i(OpAddi, t, s, imm);
      14: return enc_i(OpAddiu, t, s, imm);
      15: return enc_i(OpSlti, t, s, imm);
      16: return enc_i(OpSltiu, t, s, imm);
      17: return enc_i(OpAndi, t, s, imm);
      18: return enc_i(OpOri, t, s, imm);
      19: return enc_i(OpXori, t, s, imm);
      20: return enc_i(OpLui, t, 0, imm);
      21: return {6'h3F, 26'($urandom)};
      default: return enc_r(6'h3F, d, s, t, 0);
    endcase
  endfunction

  function automatic logic [15:0] rand_ea();
    return 16'(2048 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    run(2);
    checks++;
    if ({bus.chip_en, bus.wre, bus.oute, bus.hb_mask, bus.lb_mask} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 11111",
               {bus.chip_en, bus.wre, bus.oute, bus.hb_mask, bus.lb_mask});
    end
    checks++;
    if (bus.addr !== 18'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0", bus.addr);
    end
    go();
    checks++;
    if ({bus.addr, bus.oute, bus.chip_en, bus.wre} !== {18'h0, 3'b001}) begin
      errors++;
      $display("FAIL first_fetch: got addr=%h oute=%b ce=%b wre=%b expected addr=0 0 0 1",
               bus.addr, bus.oute, bus.chip_en, bus.wre);
    end
  endtask

  task automatic test_add_store();
    prog = '{enc_i(OpAddi, 1, 0, 16'd5), enc_i(OpAddi, 2, 0, 16'd7),
             enc_r(FnAdd, 3, 1, 2, 0), enc_i(OpSw, 3, 0, 16'd0), enc_j(16)};
    prep_prog();
    go();
    run(13);
    checks++;
    if ({mem[0], mem[1]} !== 32'h0000_0005) begin
      errors++;
      $display("FAIL add_store_hi_only: got %h%h expected 00000005", mem[0], mem[1]);
    end
    run(1);
    checks++;
    if ({mem[0], mem[1]} !== 32'h0000_000C) begin
      errors++;
      $display("FAIL add_store: got %h%h expected 0000000c", mem[0], mem[1]);
    end
    checks++;
    if (bus.addr !== 18'd8 || bus.oute !== 1'b0) begin
      errors++;
      $display("FAIL add_store_next_fetch: got addr=%h oute=%b expected 8 0",
               bus.addr, bus.oute);
    end
  endtask

  task automatic test_sub_slt();
    prog = '{enc_i(OpAddi, 1, 0, 16'd3), enc_r(FnSub, 2, 0, 1, 0), enc_r(FnSlt, 3, 2, 0, 0),
             enc_i(OpSw, 2, 0, 16'd0), enc_i(OpSw, 3, 0, 16'd4), enc_j(20)};
    prep_prog();
    go();
    run(19);
    checks++;
    if (bus.addr !== 18'd10 || bus.oute !== 1'b0) begin
      errors++;
      $display("FAIL sub_slt_cycles: got addr=%h oute=%b expected a 0", bus.addr, bus.oute);
    end
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 64'hFFFF_FFFD_0000_0001) begin
      errors++;
      $display("FAIL sub_slt_mem: got %h %h %h %h expected ffff fffd 0000 0001",
               mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_lui_lw_beq();
    prog = '{enc_i(OpLui, 1, 0, 16'h1234), enc_i(OpOri, 1, 1, 16'h5678),
             enc_i(OpSw, 1, 0, 16'd256), enc_i(OpLw, 2, 0, 16'd256),
             enc_i(OpBeq, 2, 1, 16'd1), enc_i(OpAddi, 5, 0, 16'd1),
             enc_i(OpAddi, 6, 0, 16'd2), enc_i(OpSw, 5, 0, 16'd264),
             enc_i(OpSw, 6, 0, 16'd268), enc_i(OpSw, 2, 0, 16'd272), enc_j(40)};
    prep_prog();
    go();
    run(37);
    checks++;
    if (bus.addr !== 18'd20 || bus.oute !== 1'b0) begin
      errors++;
      $display("FAIL beq_cycles: got addr=%h oute=%b expected 14 0", bus.addr, bus.oute);
    end
    checks++;
    if ({mem[128], mem[129]} !== 32'h1234_5678) begin
      errors++;
      $display("FAIL lui_ori_sw: got %h%h expected 12345678", mem[128], mem[129]);
    end
    checks++;
    if (mem_word(264) !== 32'h0) begin
      errors++;
      $display("FAIL beq_skip: got %h expected 00000000", mem_word(264));
    end
    checks++;
    if (mem_word(268) !== 32'h2) begin
      errors++;
      $display("FAIL beq_target: got %h expected 00000002", mem_word(268));
    end
    checks++;
    if (mem_word(272) !== 32'h1234_5678) begin
      errors++;
      $display("FAIL lw_value: got %h expected 12345678", mem_word(272));
    end
  endtask

  task automatic test_zero_reg_jump();
    prog = '{enc_i(OpAddi, 0, 0, 16'd9), enc_i(OpSw, 0, 0, 16'd0), enc_j(8)};
    prep_prog();
    go();
    run(8);
    checks++;
    if ({mem[0], mem[1]} !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg: got %h%h expected 00000000", mem[0], mem[1]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.addr !== 18'd4 || bus.oute !== 1'b0 || bus.chip_en !== 1'b0) begin
        errors++;
        $display("FAIL jump_self_%0d: got addr=%h oute=%b ce=%b expected 4 0 0",
                 k, bus.addr, bus.oute, bus.chip_en);
      end
      run(3);
    end
  endtask

  task automatic test_reset_mid_write();
    prog = '{enc_i(OpAddi, 1, 0, 16'h1234), enc_i(OpSw, 1, 0, 16'd1024), enc_j(8)};
    prep_prog();
    mem[512] = 16'hAAAA;
    mem[513] = 16'hBBBB;
    go();
    run(6);
    checks++;
    if (bus.wre !== 1'b0 || bus.addr !== 18'd512) begin
      errors++;
      $display("FAIL mid_write_mh: got wre=%b addr=%h expected 0 200", bus.wre, bus.addr);
    end
    reset = 1'b1;
    clk_cycle();
    checks++;
    if (bus.wre !== 1'b1 || bus.chip_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_idle: got wre=%b ce=%b expected 1 1", bus.wre, bus.chip_en);
    end
    go();
    checks++;
    if (mem[513] !== 16'hBBBB) begin
      errors++;
      $display("FAIL mid_write_lo: got %h expected bbbb", mem[513]);
    end
    checks++;
    if (bus.addr !== 18'h0 || bus.oute !== 1'b0 || bus.chip_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_write_refetch: got addr=%h oute=%b ce=%b expected 0 0 0",
               bus.addr, bus.oute, bus.chip_en);
    end
  endtask

  task automatic test_random(input int iter);
    int cyc;
    int n;
    logic [31:0] jpc;
    prog.delete();
    for (int r = 1; r < 8; r++) begin
      prog.push_back(enc_i(OpLui, r, 0, 16'($urandom)));
      prog.push_back(enc_i(OpOri, r, r, 16'($urandom)));
    end
    for (int k = 0; k < 24; k++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) prog.push_back(rand_alu());
      else if (kind == 6) prog.push_back(enc_i(OpSw, int'($urandom_range(0, 7)), 0, rand_ea()));
      else if (kind == 7) prog.push_back(enc_i(OpLw, int'($urandom_range(0, 7)), 0, rand_ea()));
      else prog.push_back(enc_i(($urandom_range(0, 1) == 0) ? OpBeq : OpBne,
                                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                16'($urandom_range(0, 2))));
    end
    for (int r = 1; r < 8; r++) prog.push_back(enc_i(OpSw, r, 0, 16'(3072 + 4 * r)));
    n = prog.size();
    prog.push_back(enc_j(4 * n));
    prep_prog();
    model_run(cyc, jpc);
    go();
    run(cyc);
    checks++;
    if (bus.addr !== {jpc[18:2], 1'b0} || bus.oute !== 1'b0) begin
      errors++;
      $display("FAIL rand%0d_cycles: got addr=%h oute=%b expected %h 0 after %0d cycles",
               iter, bus.addr, bus.oute, {jpc[18:2], 1'b0}, cyc);
    end
    for (int w = 512; w < 528; w++) begin
      checks++;
      if (mem_word(4 * w) !== m_mem[w]) begin
        errors++;
        $display("FAIL rand%0d_data_%0d: got %h expected %h", iter, w, mem_word(4 * w),
                 m_mem[w]);
      end
    end
    for (int w = 769; w < 776; w++) begin
      checks++;
      if (mem_word(4 * w) !== m_mem[w]) begin
        errors++;
        $display("FAIL rand%0d_reg_%0d: got %h expected %h", iter, w - 768, mem_word(4 * w),
                 m_mem[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_store();
    test_sub_slt();
    test_lui_lw_beq();
    test_zero_reg_jump();
    test_reset_mid_write();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
